// File: rtl/i2c_slave_bfm.sv
// i2c_slave_bfm: oversampled I2C slave responder with a byte-wide register file.
// Decodes START/STOP, answers SLAVE_ADDR, and supports pointer-set writes,
// auto-incrementing writes and reads with master ACK/NACK. With ACK_ALL set it
// falls back to ACK-ing every ninth bit and never drives read data.
//
// Ports:
//   sys_clk       system clock; SCL bit rate must not exceed sys_clk/8
//   rstn          asynchronous active-low reset
//   scl_in/sda_in raw asynchronous bus lines
//   sda_pull_low  1 = pull SDA low (open-drain drive)
//   busy          high from START to STOP
//   addr_hit      high from address ACK until STOP/START on an address match
//   wr_strobe     one-cycle pulse per data byte written, with wr_ptr/wr_data
//   rd_strobe     one-cycle pulse when a read byte is loaded for transmit
//   byte_count    bytes ACKed by slave or master since START, saturating
module i2c_slave_bfm #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h28,
  parameter int unsigned PTR_W      = 7,
  parameter logic [7:0]  INIT_SEED  = 8'h00,
  parameter bit          ACK_ALL    = 1'b0
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_pull_low,
  output logic             busy,
  output logic             addr_hit,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [7:0]       wr_data,
  output logic             rd_strobe,
  output logic [7:0]       byte_count
);

  localparam int unsigned DEPTH = 2 ** PTR_W;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WPTR,
    S_WPTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RD_MACK,
    S_IGNORE
  } state_t;

  state_t state;
  state_t state_nxt;

  // Synchronizer and history flops
  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;

  // Datapath registers
  logic [2:0]       bit_cnt;
  logic [6:0]       rx_sh;
  logic [7:0]       tx_sh;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       mem [0:DEPTH-1];

  // Next values
  logic             sda_nxt;
  logic             busy_nxt;
  logic             addr_hit_nxt;
  logic             wr_strobe_nxt;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [7:0]       wr_data_nxt;
  logic             rd_strobe_nxt;
  logic [7:0]       byte_count_nxt;
  logic [2:0]       bit_cnt_nxt;
  logic [6:0]       rx_sh_nxt;
  logic [7:0]       tx_sh_nxt;
  logic [PTR_W-1:0] ptr_nxt;
  logic             mem_we;

  // Decoded events and helpers
  logic             scl_rise_c, scl_fall_c;
  logic             sda_rise_c, sda_fall_c;
  logic             start_c, stop_c;
  logic [7:0]       rx_byte_c;
  logic             last_bit_c;
  logic             addr_match_c;
  logic [PTR_W-1:0] ptr_inc_c;
  logic [7:0]       byte_count_inc_c;

  // Two-flop synchronizers plus history; idle-high reset avoids false edges
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_h  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_h  <= 1'b1;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  assign scl_rise_c = scl_s2 & ~scl_h;
  assign scl_fall_c = ~scl_s2 & scl_h;
  assign sda_rise_c = sda_s2 & ~sda_h;
  assign sda_fall_c = ~sda_s2 & sda_h;

  // SCL must be stably high (no SCL edge this cycle) for START/STOP
  assign start_c = scl_s2 & scl_h & sda_fall_c;
  assign stop_c  = scl_s2 & scl_h & sda_rise_c;

  assign rx_byte_c        = {rx_sh, sda_s2};
  assign last_bit_c       = (bit_cnt == 3'd7);
  assign addr_match_c     = (rx_byte_c[7:1] == SLAVE_ADDR);
  assign ptr_inc_c        = ptr + PTR_W'(1);
  assign byte_count_inc_c = (byte_count == 8'hFF) ? byte_count : byte_count + 8'd1;

  // State register
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. In ACK states the first SCL fall asserts the ACK and
  // the second one (ACK already driven) ends the ACK bit.
  always_comb begin
    state_nxt = state;
    if (start_c) begin
      state_nxt = S_ADDR;
    end else if (stop_c) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_ADDR: begin
          if (scl_rise_c && last_bit_c) begin
            state_nxt = (ACK_ALL || addr_match_c) ? S_ADDR_ACK : S_IGNORE;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall_c && sda_pull_low) begin
            if (ACK_ALL) begin
              state_nxt = S_ADDR;
            end else begin
              state_nxt = rx_sh[0] ? S_RDATA : S_WPTR;
            end
          end
        end
        S_WPTR: begin
          if (scl_rise_c && last_bit_c) state_nxt = S_WPTR_ACK;
        end
        S_WPTR_ACK: begin
          if (scl_fall_c && sda_pull_low) state_nxt = S_WDATA;
        end
        S_WDATA: begin
          if (scl_rise_c && last_bit_c) state_nxt = S_WDATA_ACK;
        end
        S_WDATA_ACK: begin
          if (scl_fall_c && sda_pull_low) state_nxt = S_WDATA;
        end
        S_RDATA: begin
          if (scl_rise_c && last_bit_c) state_nxt = S_RD_MACK;
        end
        S_RD_MACK: begin
          if (scl_rise_c) state_nxt = sda_s2 ? S_IGNORE : S_RDATA;
        end
        default: ;
      endcase
    end
  end

  // Output and datapath next-value logic
  always_comb begin
    sda_nxt        = sda_pull_low;
    busy_nxt       = busy;
    addr_hit_nxt   = addr_hit;
    wr_strobe_nxt  = 1'b0;
    wr_ptr_nxt     = wr_ptr;
    wr_data_nxt    = wr_data;
    rd_strobe_nxt  = 1'b0;
    byte_count_nxt = byte_count;
    bit_cnt_nxt    = bit_cnt;
    rx_sh_nxt      = rx_sh;
    tx_sh_nxt      = tx_sh;
    ptr_nxt        = ptr;
    mem_we         = 1'b0;

    if (start_c) begin
      sda_nxt        = 1'b0;
      busy_nxt       = 1'b1;
      addr_hit_nxt   = 1'b0;
      byte_count_nxt = 8'd0;
      bit_cnt_nxt    = 3'd0;
    end else if (stop_c) begin
      sda_nxt      = 1'b0;
      busy_nxt     = 1'b0;
      addr_hit_nxt = 1'b0;
      bit_cnt_nxt  = 3'd0;
    end else begin
      case (state)
        // Receive states: shift on SCL rise; the counter wraps to 0 on bit 8
        S_ADDR, S_WPTR, S_WDATA: begin
          if (scl_rise_c) begin
            rx_sh_nxt   = rx_byte_c[6:0];
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (last_bit_c) begin
              if (state == S_ADDR) begin
                addr_hit_nxt = !ACK_ALL && addr_match_c;
              end
              if (state == S_WPTR) begin
                ptr_nxt = PTR_W'(rx_byte_c);
              end
              if (state == S_WDATA) begin
                mem_we        = 1'b1;
                wr_strobe_nxt = 1'b1;
                wr_ptr_nxt    = ptr;
                wr_data_nxt   = rx_byte_c;
                ptr_nxt       = ptr_inc_c;
              end
            end
          end
        end
        S_ADDR_ACK, S_WPTR_ACK, S_WDATA_ACK: begin
          if (scl_fall_c) begin
            if (!sda_pull_low) begin
              sda_nxt        = 1'b1;
              byte_count_nxt = byte_count_inc_c;
            end else begin
              sda_nxt = 1'b0;
              // Read request: first data bit goes out on the same fall
              if (state == S_ADDR_ACK && !ACK_ALL && rx_sh[0]) begin
                tx_sh_nxt     = mem[ptr];
                sda_nxt       = ~mem[ptr][7];
                rd_strobe_nxt = 1'b1;
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_rise_c) begin
            tx_sh_nxt   = {tx_sh[6:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 3'd1;
          end else if (scl_fall_c) begin
            sda_nxt = ~tx_sh[7];
          end
        end
        S_RD_MACK: begin
          if (scl_fall_c) begin
            sda_nxt = 1'b0;
          end else if (scl_rise_c && !sda_s2) begin
            ptr_nxt        = ptr_inc_c;
            tx_sh_nxt      = mem[ptr_inc_c];
            rd_strobe_nxt  = 1'b1;
            byte_count_nxt = byte_count_inc_c;
          end
        end
        default: ;
      endcase
    end
  end

  // Output and datapath registers
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      sda_pull_low <= 1'b0;
      busy         <= 1'b0;
      addr_hit     <= 1'b0;
      wr_strobe    <= 1'b0;
      wr_ptr       <= '0;
      wr_data      <= 8'd0;
      rd_strobe    <= 1'b0;
      byte_count   <= 8'd0;
      bit_cnt      <= 3'd0;
      rx_sh        <= 7'd0;
      tx_sh        <= 8'd0;
      ptr          <= '0;
    end else begin
      sda_pull_low <= sda_nxt;
      busy         <= busy_nxt;
      addr_hit     <= addr_hit_nxt;
      wr_strobe    <= wr_strobe_nxt;
      wr_ptr       <= wr_ptr_nxt;
      wr_data      <= wr_data_nxt;
      rd_strobe    <= rd_strobe_nxt;
      byte_count   <= byte_count_nxt;
      bit_cnt      <= bit_cnt_nxt;
      rx_sh        <= rx_sh_nxt;
      tx_sh        <= tx_sh_nxt;
      ptr          <= ptr_nxt;
    end
  end

  // Register file, re-seeded on every reset
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'(i) ^ INIT_SEED;
      end
    end else if (mem_we) begin
      mem[ptr] <= rx_byte_c;
    end
  end

endmodule

// File: tb/tb_i2c_slave_bfm.sv
// Testbench for i2c_slave_bfm: a bit-banged I2C master drives one normal
// instance and one ACK_ALL instance on separate buses. Expected values are
// queued at stimulus time; a monitor on the falling clock pops and compares.
`timescale 1ns/1ps
module tb_i2c_slave_bfm;

  localparam int unsigned PTR_W = 7;

  logic sys_clk   = 1'b0;
  logic rstn      = 1'b0;
  logic m_scl     = 1'b1;
  logic m_sda_low = 1'b0;
  logic sel_leg   = 1'b0;

  logic scl_a, sda_a, scl_b, sda_b;

  logic             a_pull, a_busy, a_hit, a_wr, a_rd;
  logic [PTR_W-1:0] a_wr_ptr;
  logic [7:0]       a_wr_data, a_cnt;
  logic             b_pull, b_busy, b_hit, b_wr, b_rd;
  logic [PTR_W-1:0] b_wr_ptr;
  logic [7:0]       b_wr_data, b_cnt;

  // Open-drain buses: low if the master or the slave pulls
  assign scl_a = sel_leg ? 1'b1 : m_scl;
  assign scl_b = sel_leg ? m_scl : 1'b1;
  assign sda_a = ~((~sel_leg & m_sda_low) | a_pull);
  assign sda_b = ~((sel_leg & m_sda_low) | b_pull);

  always #5 sys_clk = ~sys_clk;

  i2c_slave_bfm #(
    .SLAVE_ADDR(7'h28), .PTR_W(PTR_W), .INIT_SEED(8'h00), .ACK_ALL(1'b0)
  ) u_dut (
    .sys_clk(sys_clk), .rstn(rstn), .scl_in(scl_a), .sda_in(sda_a),
    .sda_pull_low(a_pull), .busy(a_busy), .addr_hit(a_hit),
    .wr_strobe(a_wr), .wr_ptr(a_wr_ptr), .wr_data(a_wr_data),
    .rd_strobe(a_rd), .byte_count(a_cnt)
  );

  i2c_slave_bfm #(
    .SLAVE_ADDR(7'h28), .PTR_W(PTR_W), .INIT_SEED(8'h00), .ACK_ALL(1'b1)
  ) u_leg (
    .sys_clk(sys_clk), .rstn(rstn), .scl_in(scl_b), .sda_in(sda_b),
    .sda_pull_low(b_pull), .busy(b_busy), .addr_hit(b_hit),
    .wr_strobe(b_wr), .wr_ptr(b_wr_ptr), .wr_data(b_wr_data),
    .rd_strobe(b_rd), .byte_count(b_cnt)
  );

  // Scoreboard
  logic [31:0]      exp_q[$];
  logic [31:0]      obs_q[$];
  string            tag_q[$];
  logic [PTR_W+7:0] exp_wr_q[$];
  int checks = 0;
  int errors = 0;
  int a_rd_cnt = 0;
  int b_strobe_cnt = 0;

  logic [31:0]      mon_obs, mon_exp;
  logic [PTR_W+7:0] mon_wr;
  string            mon_tag;

  always @(negedge sys_clk) begin
    while (obs_q.size() != 0) begin
      mon_obs = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_obs: got %0h required nothing", mon_obs);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        if (mon_obs !== mon_exp) begin
          errors++;
          $display("FAIL %s: got %0h required %0h", mon_tag, mon_obs, mon_exp);
        end
      end
    end
    if (a_wr) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got ptr %0h data %0h required no write", a_wr_ptr, a_wr_data);
      end else begin
        mon_wr = exp_wr_q.pop_front();
        if ({a_wr_ptr, a_wr_data} !== mon_wr) begin
          errors++;
          $display("FAIL wr_strobe: got ptr %0h data %0h required ptr %0h data %0h",
                   a_wr_ptr, a_wr_data, mon_wr[PTR_W+7:8], mon_wr[7:0]);
        end
      end
    end
    if (a_rd) a_rd_cnt++;
    if (b_wr || b_rd) b_strobe_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(name);
    obs_q.push_back(act);
  endtask

  // Bit-level master, quarter period 80 ns
  task automatic m_start();
    m_sda_low = 1'b0; #80;
    m_scl = 1'b1;     #80;
    m_sda_low = 1'b1; #80;
    m_scl = 1'b0;     #80;
  endtask

  task automatic m_stop();
    m_sda_low = 1'b1; #80;
    m_scl = 1'b1;     #80;
    m_sda_low = 1'b0; #80;
  endtask

  task automatic wr_bit(input logic b);
    m_sda_low = ~b; #80;
    m_scl = 1'b1;   #160;
    m_scl = 1'b0;   #80;
  endtask

  task automatic rd_bit(output logic v);
    m_sda_low = 1'b0; #80;
    m_scl = 1'b1;     #80;
    v = sel_leg ? sda_b : sda_a;
    #80;
    m_scl = 1'b0;     #80;
  endtask

  // Send a byte; exp_ack 0 = slave ACK expected
  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic a;
    exp_q.push_back(32'(exp_ack));
    tag_q.push_back(tag);
    for (int i = 7; i >= 0; i--) wr_bit(b[i]);
    rd_bit(a);
    obs_q.push_back(32'(a));
  endtask

  // Receive a byte; mack 1 = master ACKs it
  task automatic recv_byte(input logic [7:0] exp, input logic mack, input string tag);
    logic [7:0] d;
    logic v;
    exp_q.push_back(32'(exp));
    tag_q.push_back(tag);
    for (int i = 7; i >= 0; i--) begin
      rd_bit(v);
      d[i] = v;
    end
    obs_q.push_back(32'(d));
    wr_bit(~mack);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd_base;
    int n;
    repeat (4) @(negedge sys_clk);
    chk("rst_sda", 32'(a_pull), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_hit", 32'(a_hit), 32'd0);
    chk("rst_strobes", 32'({a_wr, a_rd}), 32'd0);
    chk("rst_wr_ptr_data", 32'({a_wr_ptr, a_wr_data}), 32'd0);
    chk("rst_byte_count", 32'(a_cnt), 32'd0);
    rstn = 1'b1;
    repeat (4) @(negedge sys_clk);

    // Write ptr 0x3D, data 0x0C
    m_start();
    chk("t1_busy", 32'(a_busy), 32'd1);
    send_byte(8'h50, 1'b0, "t1_addr_ack");
    chk("t1_hit", 32'(a_hit), 32'd1);
    exp_wr_q.push_back({7'h3D, 8'h0C});
    send_byte(8'h3D, 1'b0, "t1_ptr_ack");
    send_byte(8'h0C, 1'b0, "t1_data_ack");
    chk("t1_byte_count", 32'(a_cnt), 32'd3);
    m_stop();
    chk("t1_idle_busy", 32'(a_busy), 32'd0);
    chk("t1_idle_hit", 32'(a_hit), 32'd0);

    // Pointer set, repeated START, read 3 bytes ACK/ACK/NACK
    rd_base = a_rd_cnt;
    m_start();
    send_byte(8'h50, 1'b0, "t2_addr_ack");
    send_byte(8'h10, 1'b0, "t2_ptr_ack");
    m_start();
    send_byte(8'h51, 1'b0, "t2_raddr_ack");
    recv_byte(8'h10, 1'b1, "t2_rd0");
    recv_byte(8'h11, 1'b1, "t2_rd1");
    recv_byte(8'h12, 1'b0, "t2_rd2");
    chk("t2_sda_released", 32'(a_pull), 32'd0);
    chk("t2_bus_high", 32'(sda_a), 32'd1);
    chk("t2_byte_count", 32'(a_cnt), 32'd3);
    m_stop();
    chk("t2_rd_strobes", 32'(a_rd_cnt - rd_base), 32'd3);

    // Wrong address: NACK, following byte ignored
    m_start();
    send_byte(8'h52, 1'b1, "t3_addr_nack");
    chk("t3_hit", 32'(a_hit), 32'd0);
    send_byte(8'h01, 1'b1, "t3_data_ignored");
    m_stop();

    // Pointer wrap: 0x7F <- AA, 0x00 <- BB, then read back
    exp_wr_q.push_back({7'h7F, 8'hAA});
    exp_wr_q.push_back({7'h00, 8'hBB});
    m_start();
    send_byte(8'h50, 1'b0, "t4_addr_ack");
    send_byte(8'h7F, 1'b0, "t4_ptr_ack");
    send_byte(8'hAA, 1'b0, "t4_d0_ack");
    send_byte(8'hBB, 1'b0, "t4_d1_ack");
    m_stop();
    m_start();
    send_byte(8'h50, 1'b0, "t4b_addr_ack");
    send_byte(8'h7F, 1'b0, "t4b_ptr_ack");
    m_start();
    send_byte(8'h51, 1'b0, "t4b_raddr_ack");
    recv_byte(8'hAA, 1'b1, "t4b_rd_7f");
    recv_byte(8'hBB, 1'b0, "t4b_rd_00");
    m_stop();

    // STOP mid-byte: no write, pointer stays at 0x20
    m_start();
    send_byte(8'h50, 1'b0, "ab_addr_ack");
    send_byte(8'h20, 1'b0, "ab_ptr_ack");
    wr_bit(1'b1); wr_bit(1'b0); wr_bit(1'b1); wr_bit(1'b0);
    m_stop();
    m_start();
    send_byte(8'h51, 1'b0, "ab_raddr_ack");
    recv_byte(8'h20, 1'b0, "ab_rd_ptr_kept");
    m_stop();

    // Reset during read data phase
    m_start();
    send_byte(8'h50, 1'b0, "rs_addr_ack");
    send_byte(8'h3D, 1'b0, "rs_ptr_ack");
    m_start();
    send_byte(8'h51, 1'b0, "rs_raddr_ack");
    chk("rs_drive_msb0", 32'(a_pull), 32'd1);
    #3;
    rstn = 1'b0;
    #1;
    chk("rs_sda_released", 32'(a_pull), 32'd0);
    chk("rs_busy", 32'(a_busy), 32'd0);
    chk("rs_byte_count", 32'(a_cnt), 32'd0);
    m_sda_low = 1'b0;
    m_scl = 1'b1;
    repeat (4) @(negedge sys_clk);
    rstn = 1'b1;
    repeat (4) @(negedge sys_clk);
    m_start();
    send_byte(8'h51, 1'b0, "rs2_raddr_ack");
    recv_byte(8'h00, 1'b0, "rs2_rd_ptr0_seed");
    m_stop();
    m_start();
    send_byte(8'h50, 1'b0, "rs3_addr_ack");
    send_byte(8'h3D, 1'b0, "rs3_ptr_ack");
    m_start();
    send_byte(8'h51, 1'b0, "rs3_raddr_ack");
    recv_byte(8'h3D, 1'b0, "rs3_rd_reseeded");
    m_stop();

    // ACK_ALL instance: ACK on every ninth bit for any address
    sel_leg = 1'b1;
    repeat (4) @(negedge sys_clk);
    m_start();
    chk("leg_busy", 32'(b_busy), 32'd1);
    send_byte(8'h7E, 1'b0, "leg_addr_ack");
    send_byte(8'h55, 1'b0, "leg_d0_ack");
    send_byte(8'hC3, 1'b0, "leg_d1_ack");
    chk("leg_byte_count", 32'(b_cnt), 32'd3);
    m_stop();
    sel_leg = 1'b0;

    repeat (10) @(negedge sys_clk);
    n = exp_wr_q.size();
    chk("wr_missing", 32'(n), 32'd0);
    chk("leg_strobes", 32'(b_strobe_cnt), 32'd0);
    chk("leg_wr_ptr_data", 32'({b_wr_ptr, b_wr_data}), 32'd0);
    repeat (4) @(negedge sys_clk);
    n = exp_q.size();
    if (n != 0) begin
      checks++;
      errors++;
      $display("FAIL unmatched_expect: got %0d pending required 0", n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
